// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
//   Shared definitions for the quadrature encoder feedback front-end:
//     CNT_W        width of position, setpoint and error (two's complement)
//     dec_state_t  decoder FSM states (INIT / TRACK)
//     step_t       result of comparing two {A,B} samples
//     gray_step()  {A,B} transition lookup: +1 / -1 / none / illegal
//     sat_sub()    a - b evaluated one bit wider and clamped to CNT_W
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam int CNT_W = 32;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } dec_state_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // Forward order on {A,B} is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    // NOTE: s is assigned on every path, so callers in always_comb infer no latch.
    s = STEP_REV;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else begin
      case ({prev, cur})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_FWD;
        default:                                s = STEP_REV;
      endcase
    end
    return s;
  endfunction

  // Overflow of the CNT_W+1 bit difference shows up as the top two bits differing.
  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] res;
    diff = {a[CNT_W-1], a} - {b[CNT_W-1], b};
    res  = diff[CNT_W-1:0];
    if (diff[CNT_W] != diff[CNT_W-1]) begin
      res = diff[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// ---------------------------------------------------------------------------
// enc_input_filter
//   One asynchronous encoder pin: 2-FF synchronizer followed by a glitch
//   filter. The filtered level only follows the synchronized pin after
//   FILT_LEN consecutive samples that differ from the current level.
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high; level returns to 0
//     pin    raw asynchronous input
//     level  filtered, synchronous level
// ---------------------------------------------------------------------------
module enc_input_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] RUN_LAST = CW'(FILT_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] run;   // differing samples seen so far, minus one on acceptance

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others (sync[1] here is last cycle's).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      run   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        run <= '0;
      end else if (run == RUN_LAST) begin
        level <= sync[1];
        run   <= '0;
      end else begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_error.sv
// ---------------------------------------------------------------------------
// quad_encoder_error
//   Quadrature (A/B/index) decoder with signed position count and a
//   periodically sampled, saturated error e = setpoint - position.
//   Optional macro: INDEX_HOME_EN enables index-pulse homing.
//   Ports:
//     clk, reset           clock; synchronous active-high reset
//     enc_a, enc_b, enc_i  asynchronous encoder pins
//     setpoint, set_valid  target position, captured when set_valid=1
//     zero_pos             clear position this cycle (highest priority)
//     home_arm             arm index homing (INDEX_HOME_EN only)
//     position             signed position count, wraps modulo 2^CNT_W
//     e_out, e_valid       clamped error sample and its one-cycle strobe
//     dir                  direction of last accepted step (1 = forward)
//     illegal_cnt          illegal A/B transitions, saturating at 255
//     homed                index homing completed (0 without INDEX_HOME_EN)
// ---------------------------------------------------------------------------
module quad_encoder_error
  import enc_pkg::*;
#(
  parameter int FILT_LEN   = 4,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_i,
  input  logic [CNT_W-1:0] setpoint,
  input  logic             set_valid,
  input  logic             zero_pos,
  input  logic             home_arm,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] e_out,
  output logic             e_valid,
  output logic             dir,
  output logic [7:0]       illegal_cnt,
  output logic             homed
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic             a_f, b_f;
  logic [1:0]       ab_cur, ab_prev;
  dec_state_t       state;
  step_t            step;
  logic             home_evt;
  logic [CNT_W-1:0] setpoint_reg;
  logic [DIV_W-1:0] div_cnt;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset(reset), .pin(enc_a), .level(a_f)
  );
  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset(reset), .pin(enc_b), .level(b_f)
  );

  assign ab_cur = {a_f, b_f};

  always_comb begin
    step = gray_step(ab_prev, ab_cur);
  end

`ifdef INDEX_HOME_EN
  logic i_f, i_prev, armed;

  enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_i (
    .clk(clk), .reset(reset), .pin(enc_i), .level(i_f)
  );

  assign home_evt = armed & i_f & ~i_prev;

  // Arming is sticky until the first filtered index rising edge consumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_prev <= 1'b0;
      armed  <= 1'b0;
      homed  <= 1'b0;
    end else begin
      i_prev <= i_f;
      if (home_evt) begin
        armed <= 1'b0;
        homed <= 1'b1;
      end else if (home_arm) begin
        armed <= 1'b1;
        homed <= 1'b0;
      end
    end
  end
`else
  logic unused_home;
  assign unused_home = &{1'b0, enc_i, home_arm};
  assign home_evt    = 1'b0;
  assign homed       = 1'b0;
`endif

  // Decoder: INIT adopts the first filtered {A,B} without counting.
  // Clearing (zero_pos or index home) overrides any step in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT;
      ab_prev     <= 2'b00;
      position    <= '0;
      dir         <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      ab_prev <= ab_cur;
      if (state == ST_INIT) begin
        state <= ST_TRACK;
      end
      if (zero_pos || home_evt) begin
        position <= '0;
      end else if (state == ST_TRACK) begin
        case (step)
          STEP_FWD: begin
            position <= position + 1'b1;
            dir      <= 1'b1;
          end
          STEP_REV: begin
            position <= position - 1'b1;
            dir      <= 1'b0;
          end
          default: ;
        endcase
      end
      if (state == ST_TRACK && step == STEP_ILLEGAL && illegal_cnt != 8'hFF) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      setpoint_reg <= '0;
    end else if (set_valid) begin
      setpoint_reg <= setpoint;
    end
  end

  // Sample divider; the error is taken from the registered setpoint and
  // position, so a setpoint loaded on a terminal cycle lands in the next sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      e_out   <= '0;
      e_valid <= 1'b0;
    end else begin
      e_valid <= 1'b0;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        e_out   <= sat_sub(setpoint_reg, position);
        e_valid <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_error.sv
// ---------------------------------------------------------------------------
// tb_quad_encoder_error
//   Self-checking bench for quad_encoder_error. A reference model tracks the
//   encoder as a phase 0..3 on the gray circle and moves position by the
//   modular phase difference; errors are computed in 64-bit arithmetic and
//   clamped. Build with +define+INDEX_HOME_EN to exercise homing.
// ---------------------------------------------------------------------------
module tb_quad_encoder_error;

  localparam int FILT_LEN   = 4;
  localparam int SAMPLE_DIV = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enc_a = 1'b0, enc_b = 1'b0, enc_i = 1'b0;
  logic [31:0] setpoint = '0;
  logic        set_valid = 1'b0, zero_pos = 1'b0, home_arm = 1'b0;
  logic [31:0] position, e_out;
  logic        e_valid, dir, homed;
  logic [7:0]  illegal_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_pos;
  logic       m_dir;
  int         m_ill;
  logic [1:0] m_ab;

  typedef struct {
    logic [1:0] ab;
    int         exp_pos;
    logic       exp_dir;
    int         exp_ill;
  } vec_t;

  vec_t tbl [12];

  quad_encoder_error #(.FILT_LEN(FILT_LEN), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk(clk), .reset(reset),
    .enc_a(enc_a), .enc_b(enc_b), .enc_i(enc_i),
    .setpoint(setpoint), .set_valid(set_valid),
    .zero_pos(zero_pos), .home_arm(home_arm),
    .position(position), .e_out(e_out), .e_valid(e_valid),
    .dir(dir), .illegal_cnt(illegal_cnt), .homed(homed)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int ph);
    case (ph)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] exp_err(input logic [31:0] sp, input int pos);
    longint d;
    d = longint'($signed(sp)) - longint'(pos);
    if (d > 64'sh7FFF_FFFF) d = 64'sh7FFF_FFFF;
    else if (d < -64'sh8000_0000) d = -64'sh8000_0000;
    return d[31:0];
  endfunction

  // Drive a new {A,B} level, hold it long enough to settle, and update the model.
  task automatic apply_ab(input logic [1:0] ab);
    int d;
    d = (phase_of(ab) - phase_of(m_ab) + 4) % 4;
    if (d == 1) begin
      m_pos++;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_pos--;
      m_dir = 1'b0;
    end else if (d == 2 && m_ill < 255) begin
      m_ill++;
    end
    m_ab  = ab;
    enc_a = ab[1];
    enc_b = ab[0];
    step_cycles(10);
  endtask

  task automatic move(input int d);
    apply_ab(ab_of((phase_of(m_ab) + d + 4) % 4));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;
    set_valid = 1'b0; zero_pos = 1'b0; home_arm = 1'b0;
    step_cycles(3);
    reset = 1'b0;
    m_pos = 0; m_dir = 1'b0; m_ill = 0; m_ab = 2'b00;
  endtask

  task automatic check_model(input string tag);
    check({tag, " position"}, position, 32'(m_pos));
    check({tag, " dir"}, 32'(dir), 32'(m_dir));
    check({tag, " illegal_cnt"}, 32'(illegal_cnt), 32'(m_ill));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " position"}, position, 32'd0);
    check({tag, " e_out"}, e_out, 32'd0);
    check({tag, " e_valid"}, 32'(e_valid), 32'd0);
    check({tag, " dir"}, 32'(dir), 32'd0);
    check({tag, " illegal_cnt"}, 32'(illegal_cnt), 32'd0);
    check({tag, " homed"}, 32'(homed), 32'd0);
  endtask

  // Cycles until the next e_valid, sampled after each edge; bounded.
  task automatic wait_valid(output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    for (int k = 1; k <= 4 * SAMPLE_DIV; k++) begin
      @(posedge clk);
      #1;
      if (e_valid) begin
        n  = k;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_setpoint(input logic [31:0] sp);
    setpoint  = sp;
    set_valid = 1'b1;
    step_cycles(1);
    set_valid = 1'b0;
  endtask

  task automatic sample_and_check(input string tag, input logic [31:0] exp);
    int   n;
    logic ok;
    wait_valid(n, ok);
    check({tag, " e_valid seen"}, 32'(ok), 32'd1);
    if (ok) check({tag, " e_out"}, e_out, exp);
  endtask

  initial begin
    int          n;
    logic        ok;
    logic [31:0] sp_list [8];
    logic        exp_homed;

    tbl[0]  = '{2'b01, 1, 1'b1, 0};
    tbl[1]  = '{2'b11, 2, 1'b1, 0};
    tbl[2]  = '{2'b10, 3, 1'b1, 0};
    tbl[3]  = '{2'b00, 4, 1'b1, 0};
    tbl[4]  = '{2'b10, 3, 1'b0, 0};
    tbl[5]  = '{2'b11, 2, 1'b0, 0};
    tbl[6]  = '{2'b00, 2, 1'b0, 1};
    tbl[7]  = '{2'b01, 3, 1'b1, 1};
    tbl[8]  = '{2'b10, 3, 1'b1, 2};
    tbl[9]  = '{2'b00, 4, 1'b1, 2};
    tbl[10] = '{2'b10, 3, 1'b0, 2};
    tbl[11] = '{2'b11, 2, 1'b0, 2};

    // Reset state
    do_reset();
    check_reset_state("reset");

    // 8 forward cycles -> 32 counts
    for (int c = 0; c < 8; c++) begin
      apply_ab(2'b01); apply_ab(2'b11); apply_ab(2'b10); apply_ab(2'b00);
    end
    check("fwd32 position", position, 32'd32);
    check("fwd32 dir", 32'(dir), 32'd1);
    check("fwd32 illegal_cnt", 32'(illegal_cnt), 32'd0);

    // Setpoint 100 -> error 68, samples spaced SAMPLE_DIV
    load_setpoint(32'd100);
    sample_and_check("sp100", 32'd68);
    wait_valid(n, ok);
    check("sample spacing", 32'(n), 32'(SAMPLE_DIV));
    check("sp100 held e_out", e_out, 32'd68);

    // Short glitch on A is rejected
    enc_a = 1'b1;
    step_cycles(FILT_LEN - 2);
    enc_a = 1'b0;
    step_cycles(12);
    check("glitch position", position, 32'd32);
    check("glitch illegal_cnt", 32'(illegal_cnt), 32'd0);

    // 00 -> 11 jump is illegal
    apply_ab(2'b11);
    check("illegal position", position, 32'd32);
    check("illegal illegal_cnt", 32'(illegal_cnt), 32'd1);
    check("illegal dir", 32'(dir), 32'd1);

    // Pin-to-position latency: 2 + FILT_LEN + 1 edges
    m_ab = 2'b11;
    enc_a = 1'b1; enc_b = 1'b0;  // 11 -> 10 forward
    step_cycles(2 + FILT_LEN);
    check("latency before", position, 32'd32);
    step_cycles(1);
    check("latency at", position, 32'd33);
    step_cycles(3);

    // zero_pos on the same edge as an accepted step wins and drops the step
    enc_a = 1'b0; enc_b = 1'b0;  // 10 -> 00 forward
    step_cycles(2 + FILT_LEN);
    zero_pos = 1'b1;
    step_cycles(1);
    zero_pos = 1'b0;
    check("zero+step position", position, 32'd0);
    step_cycles(5);
    check("zero+step dropped", position, 32'd0);

    // Reset mid-run: everything clears, setpoint register included
    do_reset();
    check_reset_state("midrun reset");
    wait_valid(n, ok);
    check("first e_valid after reset", 32'(n), 32'(SAMPLE_DIV));
    check("post-reset e_out", e_out, 32'd0);

    // Table-driven decode vectors
    for (int i = 0; i < 12; i++) begin
      apply_ab(tbl[i].ab);
      check($sformatf("vec%0d position", i), position, 32'(tbl[i].exp_pos));
      check($sformatf("vec%0d dir", i), 32'(dir), 32'(tbl[i].exp_dir));
      check($sformatf("vec%0d illegal_cnt", i), 32'(illegal_cnt), 32'(tbl[i].exp_ill));
    end

    // Positive clamp: setpoint max, position -5
    zero_pos = 1'b1;
    step_cycles(1);
    zero_pos = 1'b0;
    m_pos = 0;
    for (int i = 0; i < 5; i++) move(-1);
    check("neg5 position", position, 32'hFFFF_FFFB);
    check("neg5 dir", 32'(dir), 32'd0);
    load_setpoint(32'h7FFF_FFFF);
    sample_and_check("clamp max", 32'h7FFF_FFFF);

    // Setpoint sweep around the negative clamp boundary, position +5
    zero_pos = 1'b1;
    step_cycles(1);
    zero_pos = 1'b0;
    m_pos = 0;
    for (int i = 0; i < 5; i++) move(1);
    check("pos5 position", position, 32'd5);
    sp_list[0] = 32'h8000_0000;
    sp_list[1] = 32'h8000_0004;
    sp_list[2] = 32'h8000_0005;
    sp_list[3] = 32'h7FFF_FFFF;
    sp_list[4] = 32'hFFFF_FF9C;
    sp_list[5] = $urandom;
    sp_list[6] = $urandom;
    sp_list[7] = $urandom;
    for (int i = 0; i < 8; i++) begin
      load_setpoint(sp_list[i]);
      sample_and_check($sformatf("sweep%0d", i), exp_err(sp_list[i], m_pos));
    end

    // Randomized moves against the phase model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: move(1);
        4, 5, 6:    move(-1);
        7:          move(2);
        8: begin
          enc_b = ~enc_b;
          step_cycles($urandom_range(1, FILT_LEN - 1));
          enc_b = m_ab[0];
          step_cycles(10);
        end
        default:    step_cycles(10);
      endcase
      check_model($sformatf("rand%0d", i));
    end

    // Index homing
    home_arm = 1'b1;
    step_cycles(1);
    home_arm = 1'b0;
    for (int i = 0; i < 3; i++) move(1);
    enc_i = 1'b1;
    step_cycles(10);
    enc_i = 1'b0;
    step_cycles(10);
`ifdef INDEX_HOME_EN
    m_pos = 0;
    exp_homed = 1'b1;
`else
    exp_homed = 1'b0;
`endif
    check("home1 position", position, 32'(m_pos));
    check("home1 homed", 32'(homed), 32'(exp_homed));
    for (int i = 0; i < 2; i++) move(1);
    enc_i = 1'b1;
    step_cycles(10);
    enc_i = 1'b0;
    step_cycles(10);
    check("home2 position", position, 32'(m_pos));
    check("home2 homed", 32'(homed), 32'(exp_homed));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
